// File: rtl/edge_pkg.sv
// Shared constants, types and helpers for the greyscale pixel fetch path.
package edge_pkg;

    // Luma weights (x256): 77/150/29 sum to 256, so full white maps to 255
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // Byte positions of the colour channels inside the bus word
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    // Legacy state encodings, kept so existing probes still decode the FSM
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT
    } fetch_state_t;

    function automatic rgb_t unpack_rgb(input logic [23:0] w);
        rgb_t p;
        p.r = w[R_LSB +: 8];
        p.g = w[G_LSB +: 8];
        p.b = w[B_LSB +: 8];
        return p;
    endfunction

    // Weighted sum; peaks at 65280 so 16 bits never overflow
    function automatic logic [15:0] luma_sum(input rgb_t p);
        return 16'(COEF_R) * 16'(p.r) + 16'(COEF_G) * 16'(p.g) + 16'(COEF_B) * 16'(p.b);
    endfunction

endpackage

// File: rtl/grey_fifo_mem.sv
// DEPTH x 8 circular buffer with registered occupancy and a held read value.
module grey_fifo_mem
    import edge_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             underflow
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       hold_q, hold_d;
    logic             do_pop;

    // Status flags and head value; the head is held once the buffer drains
    always_comb begin
        count     = count_q;
        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        underflow = pop && empty;
        rdata     = empty ? hold_q : mem_q[rd_ptr_q];
        hold_d    = rdata;
    end

    // Pointer, occupancy and storage update; clear overrides push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push && do_pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: rtl/grey_pixel_fifo.sv
// Credit-limited pixel fetcher: single-word reads from the AHB master wrapper,
// RGB-to-grey conversion stage, and a small FIFO feeding the edge-detection core.
// Define GREY_ROUND_EN to round the grey value to nearest instead of truncating.
module grey_pixel_fifo
    import edge_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             frame_done,
    input  logic             clear,
    output logic             re,
    input  logic             read_complete,
    input  logic [31:0]      pixel_word,
    input  logic             pop,
    output logic [7:0]       grey_pixel,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             underflow
);

`ifdef GREY_ROUND_EN
    localparam logic [15:0] GREY_BIAS = 16'd128;
`else
    localparam logic [15:0] GREY_BIAS = 16'd0;
`endif
    localparam logic [PTR_W+1:0] OCC_LIMIT = (PTR_W + 2)'(DEPTH);

    fetch_state_t     state_q, state_d;
    logic             discard_q, discard_d;
    logic             conv_valid_q, conv_valid_d;
    rgb_t             conv_rgb_q, conv_rgb_d;
    logic [PTR_W+1:0] occupancy;
    logic             credit_ok;
    logic [7:0]       grey_conv;
    logic             unused_hi;

    // Request strobe, slot reservation and grey conversion of the staged word
    always_comb begin
        re        = (state_q == REQ);
        occupancy = {1'b0, count} + {{(PTR_W + 1){1'b0}}, conv_valid_q};
        credit_ok = (occupancy < OCC_LIMIT);
        grey_conv = 8'((luma_sum(conv_rgb_q) + GREY_BIAS) >> 8);
        unused_hi = ^pixel_word[31:24];
    end

    // Fetch sequencing, discard tracking and capture into the conversion register
    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        conv_valid_d = 1'b0;
        conv_rgb_d   = conv_rgb_q;
        case (state_q)
            IDLE: begin
                if (enable && !frame_done && !clear && credit_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // re is already on the bus, so a clear here must still absorb the reply
                state_d   = WAIT;
                discard_d = clear;
            end
            WAIT: begin
                if (read_complete) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !clear) begin
                        conv_valid_d = 1'b1;
                        conv_rgb_d   = unpack_rgb(pixel_word[23:0]);
                    end
                end else if (clear) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            discard_q    <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_rgb_q   <= '0;
        end else begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            conv_valid_q <= conv_valid_d;
            conv_rgb_q   <= conv_rgb_d;
        end
    end

    grey_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .push      (conv_valid_q),
        .wdata     (grey_conv),
        .pop       (pop),
        .rdata     (grey_pixel),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .underflow (underflow)
    );

endmodule

// File: tb/tb_grey_pixel_fifo.sv
// Self-checking bench for grey_pixel_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_grey_pixel_fifo;

    localparam int unsigned DEPTH = 8;

`ifdef GREY_ROUND_EN
    localparam logic [7:0] E_RED = 8'h4D;
    localparam logic [7:0] E_BLU = 8'h1D;
    localparam logic [7:0] E_MIX = 8'h2E;
`else
    localparam logic [7:0] E_RED = 8'h4C;
    localparam logic [7:0] E_BLU = 8'h1C;
    localparam logic [7:0] E_MIX = 8'h2D;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        enable = 1'b0, frame_done = 1'b0, clear = 1'b0;
    logic        re, read_complete = 1'b0, pop = 1'b0;
    logic [31:0] pixel_word = '0;
    logic [7:0]  grey_pixel;
    logic        empty, full, underflow;
    logic [3:0]  count;

    always #5 clk = ~clk;

    grey_pixel_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .enable        (enable),
        .frame_done    (frame_done),
        .clear         (clear),
        .re            (re),
        .read_complete (read_complete),
        .pixel_word    (pixel_word),
        .pop           (pop),
        .grey_pixel    (grey_pixel),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .underflow     (underflow)
    );

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp;
    } vec_t;
    vec_t tv [8];

    int total = 0;
    int bad   = 0;

    // reference model state
    int unsigned exp_q [$];
    bit          conv_v, outst, disc, ok_prev, re_prev;
    int unsigned conv_b, shown;
    // bus master model state
    logic [31:0] src_q [$];
    int unsigned mst_cnt, lat, re_pulses, cyc_no, rc_at;
    bit          rand_lat;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    function automatic int unsigned ref_grey(input logic [31:0] w);
        int unsigned s;
        s = 77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0]);
`ifdef GREY_ROUND_EN
        s = s + 128;
`endif
        return s / 256;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        src_q.delete();
        conv_v = 0; outst = 0; disc = 0; ok_prev = 0; re_prev = 0;
        conv_b = 0; shown = 0; mst_cnt = 0;
    endtask

    // Advance the model over the clock edge just taken, using the inputs of
    // the cycle that ended there.
    task automatic model_update();
        bit          pre_out = outst;
        bit          new_v = 0;
        int unsigned new_b = 0;
        ok_prev = enable && !frame_done && !clear && !outst && !re_prev &&
                  (exp_q.size() + int'(conv_v) < DEPTH);
        if (pre_out && read_complete) begin
            if (!disc && !clear) begin
                new_v = 1;
                new_b = ref_grey(pixel_word);
            end
            outst = 0;
            disc  = 0;
        end else if (pre_out && clear) begin
            disc = 1;
        end
        if (re_prev) begin
            outst = 1;
            disc  = clear;
        end
        if (clear) begin
            exp_q.delete();
        end else begin
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (conv_v) exp_q.push_back(conv_b);
        end
        conv_v = new_v;
        conv_b = new_b;
        if (exp_q.size() != 0) shown = exp_q[0];
    endtask

    task automatic check_regs();
        chk("count", int'(count), exp_q.size());
        chk("empty", int'(empty), int'(exp_q.size() == 0));
        chk("full", int'(full), int'(exp_q.size() == DEPTH));
        chk("grey", int'(grey_pixel), int'(shown));
    endtask

    // One clock: called at a negedge after inputs are set; returns at the next negedge.
    task automatic next_cycle();
        #1;
        chk("underflow", int'(underflow), int'(pop && exp_q.size() == 0));
        @(negedge clk);
        cyc_no++;
        model_update();
        check_regs();
        if (re) chk("re_allowed", int'(ok_prev), 1);
        re_prev = re;
        read_complete = 1'b0;
        if (mst_cnt != 0) begin
            mst_cnt--;
            if (mst_cnt == 0) begin
                read_complete = 1'b1;
                pixel_word = (src_q.size() != 0) ? src_q.pop_front() : $urandom;
                rc_at = cyc_no;
            end
        end
        if (re) begin
            mst_cnt = rand_lat ? $urandom_range(4, 1) : lat;
            re_pulses++;
        end
    endtask

    task automatic do_read(input logic [31:0] w);
        int n = 0;
        src_q.push_back(w);
        enable = 1'b1;
        while (!re && n < 20) begin next_cycle(); n++; end
        chk("req_seen", int'(re), 1);
        enable = 1'b0;
        n = 0;
        while (!read_complete && n < 20) begin next_cycle(); n++; end
        chk("rc_seen", int'(read_complete), 1);
    endtask

    task automatic drain();
        int n = 0;
        enable = 1'b0;
        frame_done = 1'b0;
        for (int i = 0; i < 8; i++) next_cycle();
        while (!empty && n < 40) begin pop = 1'b1; next_cycle(); n++; end
        pop = 1'b0;
        chk("drained", int'(empty), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int unsigned snap;
        int unsigned re_at;
        int n;

        tv[0] = '{32'h00FF0000, E_RED};
        tv[1] = '{32'h00FFFFFF, 8'hFF};
        tv[2] = '{32'h00000000, 8'h00};
        tv[3] = '{32'h00808080, 8'h80};
        tv[4] = '{32'h0000FF00, 8'h95};
        tv[5] = '{32'h000000FF, E_BLU};
        tv[6] = '{32'hAB123456, E_MIX};
        tv[7] = '{32'h00010101, 8'h01};

        lat = 1; rand_lat = 0; re_pulses = 0; cyc_no = 0; rc_at = 0;
        model_reset();

        // reset
        #1 n_rst = 1'b0;
        #1;
        chk("rst_re", int'(re), 0);
        chk("rst_grey", int'(grey_pixel), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_underflow", int'(underflow), 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // conversion table with latency and hold checks
        for (int i = 0; i < 8; i++) begin
            do_read(tv[i].word);
            next_cycle();
            chk("lat_n1_empty", int'(empty), 1);
            next_cycle();
            chk("lat_n2_empty", int'(empty), 0);
            chk($sformatf("vec%0d_grey", i), int'(grey_pixel), int'(tv[i].exp));
            pop = 1'b1;
            next_cycle();
            pop = 1'b0;
            chk("pop_empty", int'(empty), 1);
            chk($sformatf("vec%0d_hold", i), int'(grey_pixel), int'(tv[i].exp));
        end

        // fill without pops, then one pop allows one more read
        re_pulses = 0;
        enable = 1'b1;
        for (int i = 0; i < 60; i++) next_cycle();
        chk("fill_re_pulses", int'(re_pulses), DEPTH);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        pop = 1'b1;
        next_cycle();
        pop = 1'b0;
        for (int i = 0; i < 30; i++) next_cycle();
        chk("refill_re_pulses", int'(re_pulses), DEPTH + 1);
        chk("refill_full", int'(full), 1);
        drain();

        // pop while empty
        pop = 1'b1;
        #1 chk("uf_pulse", int'(underflow), 1);
        next_cycle();
        pop = 1'b0;
        #1 chk("uf_gone", int'(underflow), 0);
        chk("uf_count", int'(count), 0);

        // simultaneous push and pop at count 3
        do_read(32'h00112233);
        do_read(32'h00445566);
        do_read(32'h00778899);
        next_cycle();
        next_cycle();
        chk("pp_pre_count", int'(count), 3);
        do_read(32'h00AABBCC);
        next_cycle();
        pop = 1'b1;
        next_cycle();
        pop = 1'b0;
        chk("pp_count", int'(count), 3);
        drain();

        // clear while a read is outstanding
        lat = 4;
        src_q.push_back(32'h00FFFFFF);
        enable = 1'b1;
        n = 0;
        while (!re && n < 20) begin next_cycle(); n++; end
        enable = 1'b0;
        next_cycle();
        clear = 1'b1;
        enable = 1'b1;
        next_cycle();
        clear = 1'b0;
        n = 0;
        while (!re && n < 20) begin next_cycle(); n++; end
        re_at = cyc_no;
        chk("clr_re_gap", int'(re_at - rc_at), 2);
        chk("clr_count", int'(count), 0);
        enable = 1'b0;
        lat = 1;
        drain();

        // frame_done with a read in flight
        lat = 2;
        src_q.push_back(32'h00808080);
        enable = 1'b1;
        n = 0;
        while (!re && n < 20) begin next_cycle(); n++; end
        frame_done = 1'b1;
        snap = re_pulses;
        for (int i = 0; i < 20; i++) next_cycle();
        chk("fd_no_re", int'(re_pulses - snap), 0);
        chk("fd_count", int'(count), 1);
        chk("fd_grey", int'(grey_pixel), 8'h80);
        frame_done = 1'b0;

        // asynchronous reset in the middle of a read
        lat = 3;
        do_read(32'h00FFFFFF);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_re", int'(re), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_grey", int'(grey_pixel), 0);
        chk("arst_full", int'(full), 0);
        model_reset();
        read_complete = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;

        // randomized traffic against the reference model
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(99) < 75);
            frame_done = ($urandom_range(99) < 8);
            clear      = ($urandom_range(99) < 3);
            pop        = ($urandom_range(99) < 45);
            next_cycle();
        end
        clear = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grey_pixel_fifo.md
Name: grey_pixel_fifo

Overview:
- Sits directly downstream of the AHB master wrapper.
- Issues single-word read requests (`re`) to the master and captures each returned 32-bit pixel word on `read_complete`.
- Converts each word to an 8-bit greyscale value through a one-stage pipeline and buffers the values in a small FIFO.
- The edge-detection core pops from the FIFO; request issue is credit-limited so the FIFO never overflows.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- enable  input  1  allow new read requests
- frame_done  input  1  address counter done; blocks new requests
- clear  input  1  synchronous flush of FIFO and pipeline
- re  output  1  one-cycle read request pulse to AHB master
- read_complete  input  1  master has a valid read word this cycle
- pixel_word  input  32  word from master: [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
- pop  input  1  consumer removes head entry
- grey_pixel  output  8  FIFO head value (valid when !empty)
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  PTR_W+1  entries held
- underflow  output  1  one-cycle pulse on pop while empty

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low on n_rst.
  - Reset values: re=0, grey_pixel=0, empty=1, full=0, count=0, underflow=0, FSM=IDLE, conv_valid=0, pointers=0.
- FSM states:
  - IDLE: if enable && !frame_done && !clear && (count + conv_valid) < DEPTH, go to REQ.
  - REQ: re=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold until read_complete, then go to IDLE. If a discard flag is set, drop the word; otherwise load it into the conversion register and set conv_valid.
- Credit rule: each read is reserved against a FIFO slot before `re` is raised. At most one read is in flight, so the FIFO cannot overflow.
- Conversion:
  - sum[15:0] = 77*R + 150*G + 29*B.
  - grey = sum[15:8].
  - Maximum sum is 65280, so there is no overflow and grey never exceeds 255.
- Latency: read_complete in cycle N → conversion register in N+1 → FIFO write at the end of N+1 → empty=0 and grey_pixel valid in cycle N+2.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - count is the registered occupancy; full = (count==DEPTH), empty = (count==0).
  - grey_pixel is driven combinationally from the head entry. It holds its last value when empty; it reads 0 after reset.
- Push and pop:
  - Push and pop in the same cycle: both take effect and count is unchanged. This is legal even when full, because the credit rule guarantees push never occurs while full without a pop.
  - Pop while empty: no state change; underflow pulses for one cycle.
- read_complete outside WAIT is ignored.
- clear:
  - Next cycle: pointers=0, count=0, conv_valid=0, FSM returns to IDLE, and re is not raised that cycle.
  - If clear arrives in WAIT (read outstanding), set the discard flag and stay in WAIT. The next read_complete is consumed and dropped, then the FSM goes to IDLE and the flag clears. This avoids a bus-protocol violation.
- frame_done: no new REQ is entered. An in-flight read and the conversion stage complete normally, and the FIFO drains via pop.
- Async reset mid-transaction: everything returns to reset values immediately. The master is reset on the same n_rst.

Optional Feature:
- GREY_ROUND_EN:
  - Defined: grey = (sum + 16'd128) >> 8, i.e. rounding to nearest. Maximum is 65408, which still fits in 16 bits, and the result is at most 255.
  - Undefined: grey = sum >> 8 (truncation).
  - Latency is unchanged either way.

Decomposition:
- Shared package `edge_pkg`:
  - localparams for the coefficients (R=77, G=150, B=29) and byte positions.
  - typedef `rgb_t` (packed struct r, g, b, 8 bits each).
  - typedef `fetch_state_t` enum {IDLE, REQ, WAIT}.
- One natural sub-module: `grey_fifo_mem`, holding the DEPTH x 8 storage and the pointer/count logic. The top level holds the FSM, the conversion register and the credit check.

Test Plan:
- Reset, then enable=1 with 0x00FF0000 returned one cycle after re → grey_pixel=0x4C (0x4D with GREY_ROUND_EN), empty=0 two cycles after read_complete.
- Words 0x00FFFFFF, 0x00000000, 0x00808080 in order → FIFO yields 0xFF, 0x00, 0x80 (truncated: 256*128>>8).
- No pops with DEPTH=8 → exactly 8 re pulses, then full=1, count=8, and re stays 0. One pop → exactly one further re.
- Pop while empty → underflow=1 for one cycle, count stays 0. Simultaneous push and pop at count=3 → count remains 3.
- clear asserted in WAIT, read_complete with 0x00FFFFFF three cycles later → word discarded, count=0, next re only after returning to IDLE.
- frame_done=1 while one read is outstanding → that pixel still lands in the FIFO, and no further re pulses are issued.
